// File: rtl/logic_cluster_pkg.sv
// Shared definitions for the logic cluster: cell config layout, config FSM states,
// and the word-count helper used to size the configuration stream.
package logic_cluster_pkg;

    localparam int CFG_BITS     = 18;
    localparam int TT_LSB       = 0;
    localparam int TT_MSB       = 15;
    localparam int CARRY_EN_BIT = 16;
    localparam int RSVD_BIT     = 17;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        COMMIT   = 2'd2,
        READBACK = 2'd3
    } cfg_state_e;

    // Stream words needed to carry every cell's config bits.
    function automatic int nwords(input int cells, input int word_w);
        return (cells * CFG_BITS + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/logic_cell_slice.sv
// One logic cell: LUT4 with optional carry substitution on I2, ripple carry
// generate, D-source mux and a flop with reset/set/enable priority.
module logic_cell_slice
    import logic_cluster_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [CFG_BITS-1:0] cfg_i,
    input  logic [3:0]          li_i,
    input  logic                cin_i,
    input  logic                cds_i,
    input  logic                qdi_i,
    input  logic                qen_i,
    input  logic                qst_i,
    input  logic                uqst_i,
    input  logic                qsts_i,
    input  logic                uqrt_i,
    output logic                fz_o,
    output logic                qz_o,
    output logic                co_o
);

    logic [TT_MSB-TT_LSB:0] tt;
    logic                   carry_en;
    logic [3:0]             lut_idx;
    logic                   set_sel;
    logic                   d_sel;
    logic                   qz_q, qz_d;
    // Reserved config bit is carried through the cluster but has no function here.
    logic                   unused_rsvd;

    assign tt          = cfg_i[TT_MSB:TT_LSB];
    assign carry_en    = cfg_i[CARRY_EN_BIT];
    assign unused_rsvd = cfg_i[RSVD_BIT];

    // With carry enabled the incoming carry replaces I2 in the LUT address.
    assign lut_idx = {li_i[3], carry_en ? cin_i : li_i[2], li_i[1], li_i[0]};
    assign fz_o    = tt[lut_idx];
    assign co_o    = carry_en & ((li_i[0] & li_i[1]) | (li_i[0] & cin_i) | (li_i[1] & cin_i));

    assign set_sel = qsts_i ? uqst_i : qst_i;
    assign d_sel   = cds_i ? qdi_i : fz_o;

    // Flop next state: user reset beats set, set beats enabled load, else hold.
    always_comb begin
        qz_d = qz_q;
        if (uqrt_i)       qz_d = 1'b0;
        else if (set_sel) qz_d = 1'b1;
        else if (qen_i)   qz_d = d_sel;
    end

    // Cell flop with synchronous cluster reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) qz_q <= 1'b0;
        else         qz_q <= qz_d;
    end

    assign qz_o = qz_q;

endmodule

// File: rtl/logic_cluster_cfg.sv
// Parametrised LUT4+FF logic cluster with ripple carry and a runtime config loader.
// Config words stream into a shadow register and are committed atomically.
// Optional build macro CLUSTER_CFG_READBACK_EN adds a readback stream of the active config.
module logic_cluster_cfg #(
    parameter int NUM_CELLS = 8,
    parameter int CFG_W     = 16,
    parameter int CFG_BITS  = logic_cluster_pkg::CFG_BITS
) (
    input  logic                   QCK,
    input  logic                   QRT,
    input  logic [4*NUM_CELLS-1:0] LI,
    input  logic                   CI,
    input  logic [NUM_CELLS-1:0]   CDS,
    input  logic [NUM_CELLS-1:0]   QDI,
    input  logic [NUM_CELLS-1:0]   QEN,
    input  logic                   QST,
    input  logic [NUM_CELLS-1:0]   UQST,
    input  logic [NUM_CELLS-1:0]   QSTS,
    input  logic [NUM_CELLS-1:0]   UQRT,
    input  logic                   cfg_start,
    input  logic                   cfg_valid,
    input  logic [CFG_W-1:0]       cfg_data,
    output logic                   cfg_ready,
    output logic                   cfg_done,
`ifdef CLUSTER_CFG_READBACK_EN
    input  logic                   rb_start,
    output logic [CFG_W-1:0]       rb_data,
    output logic                   rb_valid,
`endif
    output logic [NUM_CELLS-1:0]   FZ,
    output logic [NUM_CELLS-1:0]   QZ,
    output logic                   CO
);
    import logic_cluster_pkg::*;

    localparam int NWORDS = nwords(NUM_CELLS, CFG_W);
    localparam int TOT_W  = NUM_CELLS * CFG_BITS;
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NWORDS - 1);

    cfg_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TOT_W-1:0] shadow_q, shadow_d;
    logic [TOT_W-1:0] active_q, active_d;
    logic [NUM_CELLS:0] carry;

    // Config FSM state register.
    always_ff @(posedge QCK) begin
        if (!QRT) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Config FSM next state; start requests only honoured from IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cfg_start) state_d = LOAD;
`ifdef CLUSTER_CFG_READBACK_EN
                else if (rb_start) state_d = READBACK;
`endif
            end
            LOAD:     if (cfg_valid && (cnt_q == LAST)) state_d = COMMIT;
            COMMIT:   state_d = IDLE;
`ifdef CLUSTER_CFG_READBACK_EN
            READBACK: if (cnt_q == LAST) state_d = IDLE;
`endif
            default:  state_d = IDLE;
        endcase
    end

    // Config FSM outputs, decoded from the current state.
    always_comb begin
        cfg_ready = (state_q == LOAD);
        cfg_done  = (state_q == COMMIT);
`ifdef CLUSTER_CFG_READBACK_EN
        rb_valid  = (state_q == READBACK);
`endif
    end

    // Word counter, shadow capture and commit into the active config.
    always_comb begin
        cnt_d    = '0;
        shadow_d = shadow_q;
        active_d = active_q;
        case (state_q)
            LOAD: begin
                cnt_d = cnt_q;
                if (cfg_valid) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // Bits past the last cell in the final word have nowhere to go.
                    for (int b = 0; b < TOT_W; b++) begin
                        if (CNT_W'(b / CFG_W) == cnt_q) shadow_d[b] = cfg_data[b % CFG_W];
                    end
                end
            end
            COMMIT:   active_d = shadow_q;
`ifdef CLUSTER_CFG_READBACK_EN
            READBACK: cnt_d = cnt_q + CNT_W'(1);
`endif
            default: ;
        endcase
    end

    // Config datapath registers; reset clears both images so the cluster outputs 0.
    always_ff @(posedge QCK) begin
        if (!QRT) begin
            cnt_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

`ifdef CLUSTER_CFG_READBACK_EN
    localparam int PAD_W = NWORDS * CFG_W;
    logic [PAD_W-1:0] rb_pad;

    // Zero-extend so the unused top of the final word reads back as 0.
    assign rb_pad = PAD_W'(active_q);

    // Readback word selected by the shared word counter.
    always_comb begin
        rb_data = '0;
        if (state_q == READBACK) rb_data = rb_pad[int'(cnt_q) * CFG_W +: CFG_W];
    end
`endif

    assign carry[0] = CI;
    assign CO       = carry[NUM_CELLS];

    for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
        logic_cell_slice u_cell (
            .clk_i  (QCK),
            .rst_ni (QRT),
            .cfg_i  (active_q[i*CFG_BITS +: CFG_BITS]),
            .li_i   (LI[4*i +: 4]),
            .cin_i  (carry[i]),
            .cds_i  (CDS[i]),
            .qdi_i  (QDI[i]),
            .qen_i  (QEN[i]),
            .qst_i  (QST),
            .uqst_i (UQST[i]),
            .qsts_i (QSTS[i]),
            .uqrt_i (UQRT[i]),
            .fz_o   (FZ[i]),
            .qz_o   (QZ[i]),
            .co_o   (carry[i+1])
        );
    end

endmodule

// File: tb/tb_logic_cluster_cfg.sv
// Self-checking bench for logic_cluster_cfg (8 cells, 16-bit config words).
// Define CLUSTER_CFG_READBACK_EN to also exercise the readback stream.
module tb_logic_cluster_cfg;

    localparam int N  = 8;
    localparam int W  = 16;
    localparam int NW = 9;
    localparam int TW = N * 18;

    logic           QCK = 1'b0;
    logic           QRT;
    logic [4*N-1:0] LI;
    logic           CI;
    logic [N-1:0]   CDS, QDI, QEN, UQST, QSTS, UQRT;
    logic           QST;
    logic           cfg_start, cfg_valid;
    logic [W-1:0]   cfg_data;
    logic           cfg_ready, cfg_done;
    logic [N-1:0]   FZ, QZ;
    logic           CO;
`ifdef CLUSTER_CFG_READBACK_EN
    logic           rb_start;
    logic [W-1:0]   rb_data;
    logic           rb_valid;
`endif

    int err_cnt = 0;
    int chk_cnt = 0;

    typedef struct {
        string       tag;
        logic [63:0] v;
    } exp_t;
    exp_t sb[$];

    logic_cluster_cfg #(.NUM_CELLS(N), .CFG_W(W)) dut (
        .QCK(QCK), .QRT(QRT), .LI(LI), .CI(CI), .CDS(CDS), .QDI(QDI), .QEN(QEN),
        .QST(QST), .UQST(UQST), .QSTS(QSTS), .UQRT(UQRT),
        .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready), .cfg_done(cfg_done),
`ifdef CLUSTER_CFG_READBACK_EN
        .rb_start(rb_start), .rb_data(rb_data), .rb_valid(rb_valid),
`endif
        .FZ(FZ), .QZ(QZ), .CO(CO)
    );

    always #5 QCK = ~QCK;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [63:0] got);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 1, 0);
        end else begin
            e = sb.pop_front();
            chk(e.tag, got, e.v);
        end
    endtask

    task automatic tick();
        @(posedge QCK);
        #1;
    endtask

    function automatic logic [TW-1:0] mk_img(input logic [15:0] tt0, input logic [15:0] tt_rest,
                                             input logic cen);
        logic [TW-1:0] img;
        img = '0;
        for (int i = 0; i < N; i++) img[i*18 +: 18] = {1'b0, cen, (i == 0) ? tt0 : tt_rest};
        return img;
    endfunction

    // Cell i sees I0=a[i], I1=b[i], I2=I3=0.
    task automatic set_ab(input logic [7:0] a, input logic [7:0] b, input logic ci);
        for (int i = 0; i < N; i++) LI[4*i +: 4] = {2'b00, b[i], a[i]};
        CI = ci;
    endtask

    // Drive a cfg_start and n_send words; {CO,FZ} must stay at hold until after commit.
    task automatic cfg_load(input logic [TW-1:0] img, input int n_send, input bit stall,
                            input logic [8:0] hold, output int acc, output int dn);
        int k;
        int cyc;
        bit rdy;
        acc = 0; dn = 0; k = 0; cyc = 0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        while (k < n_send && cyc < 64) begin
            cfg_valid = stall ? ((cyc % 2) == 0) : 1'b1;
            cfg_data  = img[k*W +: W];
            #1;
            rdy = cfg_ready;
            chk("ld_hold", {CO, FZ}, hold);
            tick();
            if (cfg_valid && rdy) begin
                acc++;
                k++;
            end
            cfg_valid = 1'b0;
            if (cfg_done) dn++;
            cyc++;
        end
        if (k < n_send) chk("ld_timeout", k, n_send);
        if (n_send == NW) begin
            #1 chk("ld_commit_hold", {CO, FZ}, hold);
            tick();
            if (cfg_done) dn++;
        end
    endtask

    logic [TW-1:0] img1, img2, img3;
    int acc, dn;

    initial begin
        QRT = 1'b0; LI = '1; CI = 1'b1; CDS = '0; QDI = '0; QEN = '0; QST = 1'b0;
        UQST = '0; QSTS = '0; UQRT = '0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
`ifdef CLUSTER_CFG_READBACK_EN
        rb_start = 1'b0;
`endif
        img1 = mk_img(16'h8000, 16'h0000, 1'b0);
        img2 = mk_img(16'h9696, 16'h9696, 1'b1);

        // Reset state
        repeat (3) tick();
        push_exp("rst_fzco", 9'h000);
        #1 pop_chk({CO, FZ});
        chk("rst_qz", QZ, 8'h00);
        chk("rst_ready", cfg_ready, 0);
        chk("rst_done", cfg_done, 0);
        QRT = 1'b1;
        tick();

        // Single AND4 LUT in cell 0
        cfg_load(img1, NW, 1'b0, 9'h000, acc, dn);
        chk("t1_acc", acc, NW);
        chk("t1_done", dn, 1);
        LI = '0; CI = 1'b0;
        LI[3:0] = 4'hF;
        push_exp("t1_fz_F", 9'h001);
        #1 pop_chk({CO, FZ});
        LI[3:0] = 4'hE;
        push_exp("t1_fz_E", 9'h000);
        #1 pop_chk({CO, FZ});

        // Ripple adder
        cfg_load(img2, NW, 1'b0, 9'h000, acc, dn);
        chk("t2_done", dn, 1);
        set_ab(8'h7F, 8'h01, 1'b0); push_exp("add_7f_01", 9'h080); #1 pop_chk({CO, FZ});
        set_ab(8'hFF, 8'h01, 1'b0); push_exp("add_ff_01", 9'h100); #1 pop_chk({CO, FZ});
        set_ab(8'h55, 8'hAA, 1'b1); push_exp("add_55_aa_c", 9'h100); #1 pop_chk({CO, FZ});
        set_ab(8'h0F, 8'h01, 1'b0); push_exp("add_0f_01", 9'h010); #1 pop_chk({CO, FZ});
        set_ab(8'h00, 8'h00, 1'b1); push_exp("add_cin_only", 9'h001); #1 pop_chk({CO, FZ});

        // Flop priority
        set_ab(8'h7F, 8'h01, 1'b0);
        QEN = '1; CDS = '1; QDI = '1; QSTS = 8'h04; UQST = 8'h04; UQRT = 8'h04;
        tick(); chk("ff_uqrt_wins", QZ, 8'hFB);
        UQRT = '0;
        tick(); chk("ff_set_after", QZ, 8'hFF);
        QEN = '0; QDI = '0; QSTS = '0; UQST = '0;
        tick(); chk("ff_hold", QZ, 8'hFF);
        QEN = '1;
        tick(); chk("ff_load_qdi", QZ, 8'h00);
        QST = 1'b1;
        tick(); chk("ff_cluster_set", QZ, 8'hFF);
        QST = 1'b0; CDS = '0;
        tick(); chk("ff_load_fz", QZ, 8'h80);
        QEN = '0;

        // Stalled stream; old config holds FZ until the cycle after commit
        cfg_load(img1, NW, 1'b1, 9'h080, acc, dn);
        chk("t4_acc", acc, NW);
        chk("t4_done_once", dn, 1);
        push_exp("t4_new_fz", 9'h000);
        pop_chk({CO, FZ});
        chk("t4_qz_hold", QZ, 8'h80);

        // Reset in the middle of a load
        LI[3:0] = 4'hF;
        cfg_load(img2, 4, 1'b0, 9'h001, acc, dn);
        chk("t5_partial_acc", acc, 4);
        QRT = 1'b0;
        tick();
        chk("t5_ready", cfg_ready, 0);
        chk("t5_done", cfg_done, 0);
        chk("t5_qz", QZ, 8'h00);
        push_exp("t5_fz", 9'h000);
        pop_chk({CO, FZ});
        QRT = 1'b1;
        tick();
        cfg_load(img2, NW, 1'b0, 9'h000, acc, dn);
        chk("t5_reload_done", dn, 1);
        set_ab(8'hFF, 8'h01, 1'b0); push_exp("t5_add_ff_01", 9'h100); #1 pop_chk({CO, FZ});
        set_ab(8'h7F, 8'h01, 1'b0); push_exp("t5_add_7f_01", 9'h080); #1 pop_chk({CO, FZ});

`ifdef CLUSTER_CFG_READBACK_EN
        // Readback of a random image
        for (int i = 0; i < TW; i += 16) img3[i +: 16] = 16'($urandom);
        cfg_load(img3, NW, 1'b0, 9'h080, acc, dn);
        chk("t6_done", dn, 1);
        tick();
        rb_start = 1'b1;
        for (int k = 0; k < NW; k++) push_exp($sformatf("rb_word%0d", k), 64'(img3[k*W +: W]));
        tick();
        rb_start = 1'b0;
        begin
            int got;
            int cyc;
            got = 0; cyc = 0;
            while (got < NW && cyc < 40) begin
                cfg_start = (got == 2);
                if (rb_valid) begin
                    pop_chk(64'(rb_data));
                    got++;
                end
                tick();
                cyc++;
            end
            cfg_start = 1'b0;
            chk("rb_beats", got, NW);
        end
        chk("rb_end_valid", rb_valid, 0);
        chk("rb_start_ignored", cfg_ready, 0);
`endif

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
